// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: default geometry and stage-count helper for the pipelined carry-skip adder
package pipe_adder_pkg;
  localparam int DEF_WIDTH = 64;
  localparam int DEF_SEG = 16;
  localparam int DEF_BLK = 4;
  function automatic int nseg(input int width, input int seg);
    return width / seg;
  endfunction
endpackage

// File: rtl/carry_skip_segment.sv
// carry_skip_segment: combinational SEG-bit add from BLK-bit ripple blocks with block-propagate carry skip
module carry_skip_segment #(
  parameter int SEG = 16,
  parameter int BLK = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);
  localparam int NB = SEG / BLK;
  always_comb begin
    logic c;
    logic [BLK:0] r;
    c = cin;
    r = '0;
    sum = '0;
    for (int i = 0; i < NB; i++) begin
      r = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]} + {{BLK{1'b0}}, c};
      sum[i*BLK +: BLK] = r[BLK-1:0];
      c = &(a[i*BLK +: BLK] ^ b[i*BLK +: BLK]) ? c : r[BLK];
    end
    cout = c;
  end
endmodule

// File: rtl/pipelined_skip_adder.sv
// pipelined_skip_adder: valid/ready pipelined carry-skip adder, one SEG-bit segment per stage
// Signed overflow output ovf is built only when PIPE_ADDER_OVF_EN is defined.
module pipelined_skip_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG = DEF_SEG,
  parameter int BLK = DEF_BLK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NSEG = nseg(WIDTH, SEG);
  if (WIDTH % SEG != 0 || SEG % BLK != 0 || NSEG < 1) begin : g_bad
    $error("pipelined_skip_adder: WIDTH must be a multiple of SEG and SEG a multiple of BLK");
  end
  logic [NSEG:0] v, ld, cq;
  logic [WIDTH-1:0] aq [NSEG];
  logic [WIDTH-1:0] bq [NSEG];
  logic [WIDTH-1:0] sq [NSEG+1];
  logic [SEG-1:0] ss [NSEG];
  logic [NSEG-1:0] sc;
  for (genvar i = 0; i < NSEG; i++) begin : g_seg
    carry_skip_segment #(.SEG(SEG), .BLK(BLK)) u_seg (
      .a(aq[i][i*SEG +: SEG]),
      .b(bq[i][i*SEG +: SEG]),
      .cin(cq[i]),
      .sum(ss[i]),
      .cout(sc[i])
    );
  end
  // a stage can load if it is empty or everything below it can make room this cycle
  always_comb begin
    logic r;
    r = out_ready;
    ld = '0;
    for (int k = NSEG; k >= 0; k--) begin
      r = !v[k] || r;
      ld[k] = r;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      cq <= '0;
      for (int k = 0; k < NSEG; k++) begin
        aq[k] <= '0;
        bq[k] <= '0;
      end
      for (int k = 0; k <= NSEG; k++) sq[k] <= '0;
    end else begin
      if (ld[0]) v[0] <= in_valid;
      if (ld[0] && in_valid) begin
        aq[0] <= a;
        bq[0] <= b;
        cq[0] <= cin;
      end
      for (int k = 1; k <= NSEG; k++) begin
        if (ld[k]) v[k] <= v[k-1];
        if (ld[k] && v[k-1]) begin
          cq[k] <= sc[k-1];
          sq[k] <= sq[k-1];
          sq[k][(k-1)*SEG +: SEG] <= ss[k-1];
        end
      end
      for (int k = 1; k < NSEG; k++) begin
        if (ld[k] && v[k-1]) begin
          aq[k] <= aq[k-1];
          bq[k] <= bq[k-1];
        end
      end
    end
  end
`ifdef PIPE_ADDER_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= 1'b0;
    else if (ld[NSEG] && v[NSEG-1]) ovf <= (aq[NSEG-1][WIDTH-1] == bq[NSEG-1][WIDTH-1]) && (ss[NSEG-1][SEG-1] != aq[NSEG-1][WIDTH-1]);
  end
`endif
  assign in_ready = ld[0];
  assign out_valid = v[NSEG];
  assign sum = sq[NSEG];
  assign cout = cq[NSEG];
endmodule

// File: tb/tb_pipelined_skip_adder.sv
// tb_pipelined_skip_adder: directed vectors with hand-computed sums against pipelined_skip_adder
module tb_pipelined_skip_adder;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0;
  logic in_ready, out_valid, cout;
  logic [63:0] a = '0, b = '0, sum;
`ifdef PIPE_ADDER_OVF_EN
  logic ovf;
`endif
  int ncmp = 0, nerr = 0, got;
  logic [63:0] va [7] = '{64'h0000_0000_0000_000F, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                          64'h0000_0000_FFFF_0000, 64'h1234_5678_9ABC_DEF0, 64'h0000_FFFF_0000_FFFF,
                          64'hAAAA_AAAA_AAAA_AAAA};
  logic [63:0] vb [7] = '{64'h1, 64'h1, 64'h8000_0000_0000_0000, 64'h0000_0000_0001_0000,
                          64'h1111_1111_1111_1111, 64'h0, 64'h5555_5555_5555_5555};
  logic        vc [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [63:0] es [7] = '{64'h0000_0000_0000_0010, 64'h0, 64'h1, 64'h0000_0001_0000_0000,
                          64'h2345_6789_ABCD_F002, 64'h0000_FFFF_0001_0000, 64'h0};
  logic        ec [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  pipelined_skip_adder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input int i);
    a = va[i];
    b = vb[i];
    cin = vc[i];
    in_valid = 1'b1;
  endtask
  task automatic chk_res(input string tag, input int i);
    chk({tag, "_valid"}, 65'(out_valid), 65'd1);
    chk({tag, "_sum"}, 65'(sum), 65'(es[i]));
    chk({tag, "_cout"}, 65'(cout), 65'(ec[i]));
  endtask
  initial begin
    tick();
    tick();
    chk("rst_valid", 65'(out_valid), 65'd0);
    chk("rst_sum", 65'(sum), 65'd0);
    chk("rst_cout", 65'(cout), 65'd0);
    chk("rst_ready", 65'(in_ready), 65'd1);
`ifdef PIPE_ADDER_OVF_EN
    chk("rst_ovf", 65'(ovf), 65'd0);
`endif
    rst_n = 1'b1;
    tick();
    a = 64'hFFFF_FFFF_FFFF_FFFF;
    b = '0;
    cin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("ripple_early", 65'(out_valid), 65'd0);
    tick();
    chk("ripple_valid", 65'(out_valid), 65'd1);
    chk("ripple_sum", 65'(sum), 65'd0);
    chk("ripple_cout", 65'(cout), 65'd1);
    tick();
    for (int i = 0; i < 11; i++) begin
      if (i < 7) drive(i);
      else in_valid = 1'b0;
      tick();
      if (i >= 4) chk_res("b2b", i - 4);
    end
    tick();
    chk("b2b_drain", 65'(out_valid), 65'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(i);
      chk("bp_fill_ready", 65'(in_ready), 65'd1);
      tick();
    end
    drive(5);
    chk("bp_full_ready", 65'(in_ready), 65'd0);
    for (int s = 0; s < 6; s++) begin
      tick();
      chk("bp_stall_ready", 65'(in_ready), 65'd0);
      chk_res("bp_hold", 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 65'(in_ready), 65'd1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      in_valid = 1'b0;
      chk_res("bp_out", i);
    end
    tick();
    chk("bp_drain", 65'(out_valid), 65'd0);
    out_ready = 1'b0;
    drive(0);
    tick();
    in_valid = 1'b0;
    for (int s = 0; s < 4; s++) tick();
    chk_res("bub_first", 0);
    drive(1);
    chk("bub_ready1", 65'(in_ready), 65'd1);
    tick();
    in_valid = 1'b0;
    tick();
    drive(2);
    chk("bub_ready2", 65'(in_ready), 65'd1);
    tick();
    in_valid = 1'b0;
    for (int s = 0; s < 4; s++) tick();
    chk_res("bub_hold", 0);
    chk("bub_s0_free", 65'(in_ready), 65'd1);
    out_ready = 1'b1;
    got = 0;
    for (int t = 0; t < 20 && got < 3; t++) begin
      if (out_valid) begin
        chk_res("bub_out", got);
        got++;
      end
      tick();
    end
    chk("bub_count", 65'(got), 65'd3);
    chk("bub_drain", 65'(out_valid), 65'd0);
    drive(0);
    tick();
    drive(1);
    tick();
    drive(2);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 65'(out_valid), 65'd0);
    chk("mrst_sum", 65'(sum), 65'd0);
    chk("mrst_cout", 65'(cout), 65'd0);
    chk("mrst_ready", 65'(in_ready), 65'd1);
    tick();
    tick();
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int s = 0; s < 8; s++) begin
      tick();
      chk("mrst_no_stale", 65'(out_valid), 65'd0);
    end
    a = 64'h7FFF_FFFF_FFFF_FFFF;
    b = 64'h1;
    cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int s = 0; s < 4; s++) tick();
    chk("ovf_valid", 65'(out_valid), 65'd1);
    chk("ovf_sum", 65'(sum), 65'(64'h8000_0000_0000_0000));
    chk("ovf_cout", 65'(cout), 65'd0);
`ifdef PIPE_ADDER_OVF_EN
    chk("ovf_flag", 65'(ovf), 65'd1);
`endif
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end
endmodule
